ifu_fetch: RTL and testbench

//  Instruction-fetch front end. Owns the architectural PC, issues one fetch at a

---
 rtl/ifu_fetch.sv | 123 ++++++++++++
 tb/tb_ifu_fetch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// and buffers one {pc, inst} entry for decode. Branch redirects squash wrong-path work.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_valid_q;
  logic        id_valid_q, id_valid_d;
  logic [63:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        req_fire;

  assign req_fire = req_valid_q & imem_req_ready;

  // Redirect overrides every other event; drop marks a response that belongs to the old path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (br_e) begin
      pc_d       = {br_addr[63:2], 2'b00};
      id_valid_d = 1'b0;
      case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_fire) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              id_valid_d = 1'b1;
              id_pc_d    = pc_q;
              id_inst_d  = imem_resp_data;
              pc_d       = pc_q + 64'd4;
              state_d    = ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (id_ready) begin
            id_valid_d = 1'b0;
            state_d    = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // Request valid is registered so the first request appears the cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 64'h0;
      id_inst_q   <= 32'h0000_0013;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      req_valid_q <= (state_d == ST_REQ);
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs change and outputs are sampled on the falling edge.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        br_e;
  logic [63:0] br_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  int errors = 0;
  int checks = 0;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .br_e(br_e), .br_addr(br_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; br_e = 1'b0; br_addr = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;
    tick(); tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_id_valid: got %b expected 0", id_valid); end
    checks++; if (id_pc !== 64'h0) begin errors++; $display("[TB] FAIL rst_id_pc: got %h expected 0", id_pc); end
    checks++; if (id_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL rst_id_inst: got %h expected 00000013", id_inst); end
    checks++; if (imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 80000000", imem_req_addr); end
  endtask

  task automatic test_basic_fetch();
    rst_n = 1'b1; imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL first_req_addr: got %h expected 80000000", imem_req_addr); end
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_no_req: got %b expected 0", imem_req_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0093;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_id_valid: got %b expected 1", id_valid); end
    checks++; if (id_pc !== 64'h8000_0000) begin errors++; $display("[TB] FAIL basic_id_pc: got %h expected 80000000", id_pc); end
    checks++; if (id_inst !== 32'h0000_0093) begin errors++; $display("[TB] FAIL basic_id_inst: got %h expected 00000093", id_inst); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_inst !== 32'h0000_0093 || id_pc !== 64'h8000_0000) begin
        errors++; $display("[TB] FAIL stall_stable[%0d]: got req=%b idv=%b pc=%h inst=%h expected req=0 idv=1 pc=80000000 inst=00000093", i, imem_req_valid, id_valid, id_pc, id_inst);
      end
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL accept_id_valid: got %b expected 0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin errors++; $display("[TB] FAIL next_req: got v=%b addr=%h expected v=1 addr=80000004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    tick();
    imem_req_ready = 1'b0; br_e = 1'b1; br_addr = 64'h8000_1003;
    tick();
    br_e = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_DEAD;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_id_valid: got %b expected 0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin errors++; $display("[TB] FAIL redirect_req: got v=%b addr=%h expected v=1 addr=80001000", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_idle: got req=%b idv=%b expected 0 0", imem_req_valid, id_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0113;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_1000 || id_inst !== 32'h00A0_0113) begin errors++; $display("[TB] FAIL target_deliver: got v=%b pc=%h inst=%h expected v=1 pc=80001000 inst=00a00113", id_valid, id_pc, id_inst); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1004) begin errors++; $display("[TB] FAIL target_next: got v=%b addr=%h expected v=1 addr=80001004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_collisions();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0BAD;
    br_e = 1'b1; br_addr = 64'h8000_2000;
    tick();
    br_e = 1'b0; imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL resp_br_idv: got %b expected 0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin errors++; $display("[TB] FAIL resp_br_req: got v=%b addr=%h expected v=1 addr=80002000", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1; br_e = 1'b1; br_addr = 64'h8000_3000;
    tick();
    br_e = 1'b0; imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL hs_br_wait: got %b expected 0", imem_req_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL hs_br_drop: got %b expected 0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000) begin errors++; $display("[TB] FAIL hs_br_req: got v=%b addr=%h expected v=1 addr=80003000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall_redirect();
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000) begin errors++; $display("[TB] FAIL stall_hold: got v=%b addr=%h expected v=1 addr=80003000", imem_req_valid, imem_req_addr); end
    br_e = 1'b1; br_addr = 64'h8000_4008;
    tick();
    br_e = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4008) begin errors++; $display("[TB] FAIL stall_switch: got v=%b addr=%h expected v=1 addr=80004008", imem_req_valid, imem_req_addr); end
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4008) begin errors++; $display("[TB] FAIL stall_keep: got v=%b addr=%h expected v=1 addr=80004008", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0033;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_4008 || id_inst !== 32'h0000_0033) begin errors++; $display("[TB] FAIL stall_deliver: got v=%b pc=%h inst=%h expected v=1 pc=80004008 inst=00000033", id_valid, id_pc, id_inst); end
    br_e = 1'b1; br_addr = 64'hFFFF_FFFF_FFFF_FFFE; id_ready = 1'b1;
    tick();
    br_e = 1'b0; id_ready = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL out_br_idv: got %b expected 0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL out_br_req: got v=%b addr=%h expected v=1 addr=fffffffffffffffc", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap_and_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_deliver: got v=%b pc=%h expected v=1 pc=fffffffffffffffc", id_valid, id_pc); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("[TB] FAIL wrap_addr: got v=%b addr=%h expected v=1 addr=0", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL async_rst: got idv=%b req=%b addr=%h expected 0 0 80000000", id_valid, imem_req_valid, imem_req_addr); end
    tick();
    rst_n = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL stray_resp: got idv=%b req=%b addr=%h expected 0 1 80000000", id_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0093;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0000 || id_inst !== 32'h0000_0093) begin errors++; $display("[TB] FAIL post_rst_fetch: got v=%b pc=%h inst=%h expected v=1 pc=80000000 inst=00000093", id_valid, id_pc, id_inst); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_collisions();
    test_stall_redirect();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
